// File: rtl/cpu_param_if.sv
// Memory bus between cpu_param and its external memory: request/ready handshake
// with wait-state support. Master is the core, slave is the memory.
interface cpu_param_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_param.sv
// Parametrised multicycle CPU: 4-entry register file, Z/C flags, two-word ops
// with an operand word, external memory via a request/ready handshake.
module cpu_param #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  cpu_param_if.master bus,
  output logic        halt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPER, S_MEM, S_EXEC, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_LD,  OP_ST,  OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_XOR, OP_NOT, OP_MOV, OP_JMP, OP_JZ,  OP_JC,  OP_JR,  OP_HLT
  } op_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    ir_q, ir_d;
  logic [DW-1:0] rf_q [4];
  logic [DW-1:0] rf_d [4];
  logic          z_q, z_d;
  logic          c_q, c_d;

  op_t           op;
  logic [1:0]    rd, rs;
  logic [DW-1:0] rd_val, rs_val;
  logic          two_word, is_alu, taken, xfer;
  logic [DW:0]   alu_res;

  assign op       = op_t'(ir_q[7:4]);
  assign rd       = ir_q[3:2];
  assign rs       = ir_q[1:0];
  assign rd_val   = rf_q[rd];
  assign rs_val   = rf_q[rs];
  assign two_word = op inside {OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JC};
  assign is_alu   = op inside {[OP_ADD:OP_NOT]};
  assign taken    = (op == OP_JMP) || (op == OP_JZ && z_q) || (op == OP_JC && c_q);
  assign xfer     = bus.mem_req & bus.mem_ready;

  // Request is gated by rst so an access in flight drops in the reset cycle itself.
  always_comb begin
    bus.mem_req   = !rst && (state_q inside {S_FETCH, S_OPER, S_MEM});
    bus.mem_we    = (state_q == S_MEM) && (op == OP_ST);
    bus.mem_addr  = (state_q == S_MEM) ? addr_q : pc_q;
    bus.mem_wdata = rs_val;
    halt          = !rst && (state_q == S_HALT);
  end

  // Bit DW carries the ADD carry-out; for SUB it is the borrow (rs > rd unsigned).
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = {1'b0, rd_val} + {1'b0, rs_val};
      OP_SUB:  alu_res = {1'b0, rd_val} - {1'b0, rs_val};
      OP_AND:  alu_res = {1'b0, rd_val & rs_val};
      OP_OR:   alu_res = {1'b0, rd_val | rs_val};
      OP_XOR:  alu_res = {1'b0, rd_val ^ rs_val};
      OP_NOT:  alu_res = {1'b0, ~rd_val};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    rf_d    = rf_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_FETCH: begin
        if (xfer) begin
          ir_d    = bus.mem_rdata[7:0];
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (two_word) begin
          state_d = S_OPER;
        end else if (op == OP_HLT) begin
          state_d = S_HALT;
        end else if (op == OP_JR) begin
          pc_d    = AW'(rs_val);
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_OPER: begin
        if (xfer) begin
          addr_d = AW'(bus.mem_rdata);
          pc_d   = taken ? AW'(bus.mem_rdata) : pc_q + AW'(1);
          if (op == OP_LDI) rf_d[rd] = bus.mem_rdata;
          state_d = (op == OP_LD || op == OP_ST) ? S_MEM : S_FETCH;
        end
      end
      S_MEM: begin
        if (xfer) begin
          if (op == OP_LD) rf_d[rd] = bus.mem_rdata;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_alu) begin
          rf_d[rd] = alu_res[DW-1:0];
          z_d      = ~|alu_res[DW-1:0];
          c_d      = alu_res[DW];
        end else if (op == OP_MOV) begin
          rf_d[rd] = rs_val;
        end
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_cpu_param.sv
// Bench for cpu_param: ALU vector table, hand-written multi-cycle sequences,
// and random straight-line programs checked against an instruction-level model.
module tb_cpu_param;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_v = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Main core: DW=8, AW=8
  cpu_param_if #(.DW(8), .AW(8)) bus ();
  logic halt;
  cpu_param #(.DW(8), .AW(8)) dut (.clk(clk), .rst(rst), .bus(bus), .halt(halt));

  // Narrow-address core: DW=8, AW=4
  cpu_param_if #(.DW(8), .AW(4)) bus_a ();
  logic halt_a;
  cpu_param #(.DW(8), .AW(4)) dut_a (.clk(clk), .rst(rst_v), .bus(bus_a), .halt(halt_a));

  // Wide core: DW=16, AW=10
  cpu_param_if #(.DW(16), .AW(10)) bus_b ();
  logic halt_b;
  cpu_param #(.DW(16), .AW(10)) dut_b (.clk(clk), .rst(rst_v), .bus(bus_b), .halt(halt_b));

  logic [7:0]  mem   [256];
  logic [7:0]  mem_a [16];
  logic [15:0] mem_b [1024];

  assign bus.mem_rdata   = mem[bus.mem_addr];
  assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];
  assign bus_b.mem_rdata = mem_b[bus_b.mem_addr];

  // 0: always ready, 1: random, 2: writes wait 3 cycles, 3: address 0x90 never ready
  int rdy_mode = 0;
  int wait_cnt = 0;
  int n_writes = 0;
  logic [7:0]  rd_log [$];
  logic [15:0] wr_log [$];
  logic [3:0]  log_a  [$];
  logic [9:0]  log_b  [$];

  initial begin
    bus_a.mem_ready = 1'b1;
    bus_b.mem_ready = 1'b1;
  end

  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.mem_ready = 1'b1;
        1:       bus.mem_ready = 1'($urandom_range(0, 1));
        2:       bus.mem_ready = !bus.mem_we || (wait_cnt >= 3);
        default: bus.mem_ready = (bus.mem_addr != 8'h90);
      endcase
    end
  end

  // Memory slave and bus monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rd_log.delete(); wr_log.delete(); n_writes = 0; wait_cnt = 0;
    end else if (bus.mem_req) begin
      if (bus.mem_we) wr_log.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.mem_ready) begin
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          n_writes++;
        end else begin
          rd_log.push_back(bus.mem_addr);
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    if (rst_v) begin
      log_a.delete(); log_b.delete();
    end else begin
      if (bus_a.mem_req) log_a.push_back(bus_a.mem_addr);
      if (bus_b.mem_req) log_b.push_back(bus_b.mem_addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int op, input int rd, input int rs);
    return 8'((op << 4) | (rd << 2) | rs);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    int hc;
    hc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (halt) begin
        hc = n;
        break;
      end
    end
    n_chk++;
    if (hc < 0) begin
      n_fail++;
      $display("FAIL %s_timeout: halt not seen within %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    int op; int a; int b; int r; int z; int c;
  } alu_vec_t;

  alu_vec_t vt [16];
  int exp_j [13] = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h40, 'h41, 'h42, 'h43, 'h44, 'h45};
  int exp_a [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 'hF, 0, 1, 'hA, 'hF, 0};

  initial begin
    int hc, bad, a, op, rd, rs, x, s, mz, mc, found;
    int mr [4];
    int dm [256];

    vt[0]  = '{4,  'hFF, 'h01, 'h00, 1, 1};
    vt[1]  = '{4,  'h12, 'h34, 'h46, 0, 0};
    vt[2]  = '{4,  'h80, 'h80, 'h00, 1, 1};
    vt[3]  = '{5,  'h05, 'h03, 'h02, 0, 0};
    vt[4]  = '{5,  'h03, 'h05, 'hFE, 0, 1};
    vt[5]  = '{5,  'h07, 'h07, 'h00, 1, 0};
    vt[6]  = '{6,  'hF0, 'h3C, 'h30, 0, 0};
    vt[7]  = '{6,  'h0F, 'hF0, 'h00, 1, 0};
    vt[8]  = '{7,  'hA0, 'h05, 'hA5, 0, 0};
    vt[9]  = '{7,  'h00, 'h00, 'h00, 1, 0};
    vt[10] = '{8,  'h55, 'hFF, 'hAA, 0, 0};
    vt[11] = '{8,  'h5A, 'h5A, 'h00, 1, 0};
    vt[12] = '{9,  'hFF, 'h12, 'h00, 1, 0};
    vt[13] = '{9,  'h0F, 'h00, 'hF0, 0, 0};
    vt[14] = '{10, 'h00, 'hC3, 'hC3, 0, 0};
    vt[15] = '{0,  'h11, 'h22, 'h11, 0, 0};

    for (int i = 0; i < 16; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 1024; i++) mem_b[i] = 16'h0000;

    // ALU table: LDI r0,a; LDI r1,b; OP r0,r1; HLT
    rdy_mode = 0;
    foreach (vt[i]) begin
      clear_mem();
      mem[0] = enc(1, 0, 0); mem[1] = 8'(vt[i].a);
      mem[2] = enc(1, 1, 0); mem[3] = 8'(vt[i].b);
      mem[4] = enc(vt[i].op, 0, 1);
      mem[5] = enc(15, 0, 0);
      reset_dut();
      run_to_halt($sformatf("alu%0d", i), 40);
      chk($sformatf("alu%0d_r0", i), dut.rf_q[0], vt[i].r);
      chk($sformatf("alu%0d_z", i), dut.z_q, vt[i].z);
      chk($sformatf("alu%0d_c", i), dut.c_q, vt[i].c);
    end

    // rd == rs
    clear_mem();
    mem[0] = enc(1, 1, 0); mem[1] = 8'h09;
    mem[2] = enc(5, 1, 1); mem[3] = enc(15, 0, 0);
    reset_dut();
    run_to_halt("subself", 40);
    chk("subself_r1", dut.rf_q[1], 0);
    chk("subself_z", dut.z_q, 1);
    chk("subself_c", dut.c_q, 0);

    // Zero-wait program with reset-state and halt timing checks
    clear_mem();
    mem[0] = enc(1, 0, 0); mem[1] = 8'h05;
    mem[2] = enc(1, 1, 0); mem[3] = 8'h03;
    mem[4] = enc(5, 0, 1); mem[5] = enc(15, 0, 0);
    reset_dut();
    hc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("first_req", bus.mem_req, 1);
        chk("first_addr", bus.mem_addr, 0);
        chk("rst_regs", {dut.rf_q[0], dut.rf_q[1], dut.rf_q[2], dut.rf_q[3]}, 0);
        chk("rst_flags", {dut.z_q, dut.c_q}, 0);
      end
      if (halt) begin
        hc = n;
        break;
      end
    end
    chk("halt_cycle", hc, 11);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_req || !halt) bad++;
    end
    chk("halt_hold", bad, 0);
    chk("prog1_r0", dut.rf_q[0], 2);
    chk("prog1_zc", {dut.z_q, dut.c_q}, 0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_halt", halt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Carry out, taken JC, OR clears Z, untaken JZ falls through
    clear_mem();
    mem[0] = enc(1, 0, 0); mem[1] = 8'hFF;
    mem[2] = enc(1, 1, 0); mem[3] = 8'h01;
    mem[4] = enc(4, 0, 1);
    mem[5] = enc(13, 0, 0); mem[6] = 8'h40;
    mem[8'h40] = enc(1, 2, 0); mem[8'h41] = 8'h11;
    mem[8'h42] = enc(7, 2, 2);
    mem[8'h43] = enc(12, 0, 0); mem[8'h44] = 8'h60;
    mem[8'h45] = enc(15, 0, 0);
    mem[8'h60] = enc(15, 0, 0);
    reset_dut();
    run_to_halt("jump", 60);
    chk("jump_len", rd_log.size(), 13);
    for (int i = 0; i < 13; i++)
      chk($sformatf("jump_addr%0d", i), (i < rd_log.size()) ? rd_log[i] : 8'hxx, exp_j[i]);
    chk("jump_r0", dut.rf_q[0], 0);
    chk("jump_r2", dut.rf_q[2], 8'h11);
    chk("jump_zc", {dut.z_q, dut.c_q}, 0);

    // Store with three wait states, then load back
    clear_mem();
    rdy_mode = 2;
    mem[0] = enc(1, 2, 0); mem[1] = 8'hA5;
    mem[2] = enc(3, 0, 2); mem[3] = 8'h80;
    mem[4] = enc(2, 3, 0); mem[5] = 8'h80;
    mem[6] = enc(15, 0, 0);
    reset_dut();
    run_to_halt("st", 80);
    chk("st_hold_cycles", wr_log.size(), 4);
    bad = 0;
    foreach (wr_log[i]) if (wr_log[i] !== 16'h80A5) bad++;
    chk("st_hold_stable", bad, 0);
    chk("st_nwrites", n_writes, 1);
    chk("st_mem", mem[8'h80], 8'hA5);
    chk("ld_r3", dut.rf_q[3], 8'hA5);

    // Random straight-line programs against the instruction-level model
    rdy_mode = 1;
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      for (int k = 0; k < 256; k++) dm[k] = 0;
      for (int k = 'hC0; k < 'hC8; k++) begin
        mem[k] = 8'($urandom);
        dm[k]  = int'(mem[k]);
      end
      mr = '{0, 0, 0, 0};
      mz = 0; mc = 0; a = 0;
      for (int i = 0; i < 12; i++) begin
        op = $urandom_range(0, 10);
        rd = $urandom_range(0, 3);
        rs = $urandom_range(0, 3);
        x  = (op == 1) ? $urandom_range(0, 255) : 'hC0 + $urandom_range(0, 7);
        mem[a] = enc(op, rd, rs); a++;
        if (op >= 1 && op <= 3) begin
          mem[a] = 8'(x); a++;
        end
        case (op)
          1: mr[rd] = x;
          2: mr[rd] = dm[x];
          3: dm[x] = mr[rs];
          4: begin s = mr[rd] + mr[rs]; mc = (s > 255); mr[rd] = s % 256; mz = (mr[rd] == 0); end
          5: begin mc = (mr[rs] > mr[rd]); mr[rd] = (mr[rd] - mr[rs] + 256) % 256; mz = (mr[rd] == 0); end
          6: begin mr[rd] = mr[rd] & mr[rs]; mc = 0; mz = (mr[rd] == 0); end
          7: begin mr[rd] = mr[rd] | mr[rs]; mc = 0; mz = (mr[rd] == 0); end
          8: begin mr[rd] = mr[rd] ^ mr[rs]; mc = 0; mz = (mr[rd] == 0); end
          9: begin mr[rd] = 255 - mr[rd]; mc = 0; mz = (mr[rd] == 0); end
          10: mr[rd] = mr[rs];
          default: ;
        endcase
      end
      mem[a] = enc(15, 0, 0);
      reset_dut();
      run_to_halt($sformatf("rnd%0d", t), 1000);
      for (int k = 0; k < 4; k++)
        chk($sformatf("rnd%0d_r%0d", t, k), dut.rf_q[k], mr[k]);
      chk($sformatf("rnd%0d_z", t), dut.z_q, mz);
      chk($sformatf("rnd%0d_c", t), dut.c_q, mc);
      bad = 0;
      for (int k = 'hC0; k < 'hC8; k++) if (int'(mem[k]) != dm[k]) bad++;
      chk($sformatf("rnd%0d_mem", t), bad, 0);
    end

    // Reset during a stalled LD data access
    clear_mem();
    rdy_mode = 3;
    mem[0] = enc(2, 1, 0); mem[1] = 8'h90; mem[2] = enc(15, 0, 0);
    mem[8'h90] = 8'h77;
    reset_dut();
    found = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == 8'h90 && !bus.mem_we) begin
        found = 1;
        break;
      end
    end
    chk("abort_reached", found, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_req", bus.mem_req, 0);
    @(posedge clk); #1 rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("abort_refetch", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h00});
    chk("abort_r1", dut.rf_q[1], 0);

    // Narrow and wide cores
    mem_a[0]   = enc(13, 0, 0); mem_a[1] = 8'h0A;
    mem_a[2]   = enc(1, 1, 0);  mem_a[3] = 8'h1F;
    mem_a[4]   = enc(1, 0, 0);  mem_a[5] = 8'hFF;
    mem_a[6]   = enc(4, 0, 0);
    mem_a[7]   = enc(11, 0, 0); mem_a[8] = 8'h0F;
    mem_a[10]  = enc(14, 0, 1);
    mem_a[15]  = enc(0, 0, 0);
    mem_b[0]   = 16'hA510; mem_b[1] = 16'hFFFF;
    mem_b[2]   = 16'h3C14; mem_b[3] = 16'h0002;
    mem_b[4]   = 16'h0041;
    mem_b[5]   = 16'h7728; mem_b[6] = 16'hFFFF;
    mem_b[7]   = 16'h00F0;
    mem_b[10'h3FF] = 16'hBEEF;
    @(posedge clk); #1 rst_v = 1'b0;
    repeat (60) @(negedge clk);
    chk("aw4_len", (log_a.size() >= 15) ? 1 : 0, 1);
    for (int i = 0; i < 15; i++)
      chk($sformatf("aw4_addr%0d", i), (i < log_a.size()) ? log_a[i] : 4'hx, exp_a[i]);
    chk("dw16_halt", halt_b, 1);
    chk("dw16_r0", dut_b.rf_q[0], 16'h0001);
    chk("dw16_c", dut_b.c_q, 1);
    chk("dw16_z", dut_b.z_q, 0);
    chk("dw16_ld_addr", (log_b.size() > 7) ? log_b[7] : 10'hx, 10'h3FF);
    chk("dw16_r2", dut_b.rf_q[2], 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
